seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-pattern detector for the sequence-detection experiments. A runtime-loadable pattern of up to `PAT_W` bits is compared against a valid-qualified serial input stream. The block emits a registered one-cycle match pulse and keeps a saturating match count. Overlapping or non-overlapping detection is selectable. It replaces fixed, hard-coded-state detectors with a single configurable block driven by the test harness.

## Interface

**Parameters**
- `PAT_W`, default 8: maximum pattern length in bits (≥2).
- `CNT_W`, default 16: width of the match counter.
- `LEN_W`, derived as $clog2(PAT_W+1): width of length fields.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `cfg_we` in 1: load configuration this cycle.
- `cfg_pattern` in PAT_W: pattern; bit `len-1` is the first bit received, bit 0 the last.
- `cfg_len` in LEN_W: pattern length.
- `cfg_overlap` in 1: 1 = overlapping detection, 0 = non-overlapping.
- `in_valid` in 1: `in_bit` is valid this cycle.
- `in_bit` in 1: serial data bit.
- `cnt_clr` in 1: clear the match counter.
- `armed` out 1: a valid configuration is loaded.
- `match` out 1: registered one-cycle pulse on detection.
- `match_count` out CNT_W: saturating number of matches.

## Operation

- **FSM states:** IDLE and ARMED.
- **Reset:** state IDLE; `pattern`, `len`, `overlap`, `hist`, `fill` cleared to 0; `armed`, `match` and `match_count` are 0.
- **Config load (`cfg_we`=1), any state:**
  - Latch `pattern`, `overlap` and the effective length.
  - Effective length = `min(cfg_len, PAT_W)`.
  - Effective length 0 → IDLE; otherwise → ARMED.
  - Clear `hist` and `fill`.
  - Any `in_bit` in the same cycle is discarded and `match` is 0 next cycle.
- **IDLE:** input is ignored and `match` stays 0.
- **ARMED, `in_valid`=1:**
  - `hist <= {hist[PAT_W-2:0], in_bit}`.
  - `fill <= min(fill+1, PAT_W)`.
  - Hit when `fill_next ≥ len` and `hist_next[len-1:0] == pattern[len-1:0]`; higher bits are masked.
- **On a hit:**
  - `match` = 1 for the next cycle only.
  - Overlap=0: `fill` forced to 0, so the next match needs `len` fresh bits.
  - Overlap=1: `fill` is unchanged.
- **ARMED, `in_valid`=0:** `hist` and `fill` hold, and `match` is 0.
- **Counter:**
  - Increments on each hit and saturates at 2^CNT_W−1.
  - `cnt_clr` alone → 0.
  - `cnt_clr` together with a hit → 1.
  - `cfg_we` does not clear the counter.
- **Priority:** `rst` > `cfg_we` > `in_valid`.

## Timing

- Latency is 1 cycle: a bit accepted at edge N produces `match` high during cycle N+1.
- `armed` is valid the cycle after `cfg_we`.
- Full rate: one bit per cycle, with back-to-back matches possible in overlap mode (e.g. pattern `11`, len 2).
- Reset mid-stream drops all partial history; no match is reported for bits accepted before reset.
- `match_count` updates in the same cycle that `match` rises.

## Structure

- **Package `seq_det_pkg`:** state enum `{IDLE, ARMED}` and a function computing `LEN_W` from `PAT_W`.
- **Sub-module `sat_counter`:** a parametrised saturating up-counter (`inc`, `clr`, width `CNT_W`).
- All remaining logic (FSM, history shifter, masked compare) lives in `seq_detector_param`.

## Test plan

- **Overlap:** load pattern `1011`, len 4, overlap=1; stream 1,0,1,1,0,1,1 → `match` one cycle after bits 4 and 7; `match_count`=2.
- **Non-overlap:** same stream with overlap=0 → one match after bit 4 only; `match_count`=1.
- **Length clamp and masking:** PAT_W=8; `cfg_len`=12 → effective len 8, pattern `8'hA5` detected after 8 bits. Then `cfg_len`=3 with pattern `8'hF5` → only `101` is compared; stream 1,0,1 → match.
- **Stall and reload:** gaps in `in_valid` inside a pattern still match. `cfg_we` asserted after 3 of 4 bits → the fourth bit gives no match and `fill` restarts.
- **Disable via len 0:** `cfg_len`=0 → `armed`=0 and no matches for any stream.
- **Counter edges:** with CNT_W=4, 16 overlapping matches of pattern `1` → count saturates at 15. `cnt_clr` together with a hit → count=1. Reset mid-pattern → no match and all outputs 0.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  // Width needed to hold any length from 0 up to pat_w inclusive.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Configuration, serial input and result signals of the pattern detector.
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
);
  localparam int LEN_W = len_w(PAT_W);

  // No back-pressure: in_bit is consumed on every edge where in_valid is high
  // and cfg_we is low; match is a one-cycle registered pulse.
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             in_valid;
  logic             in_bit;
  logic             cnt_clr;
  logic             armed;
  logic             match;
  logic [CNT_W-1:0] match_count;
  state_e           dbg_state;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit, cnt_clr,
    input  armed, match, match_count, dbg_state
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit, cnt_clr,
    output armed, match, match_count, dbg_state
  );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter; a clear that coincides with an increment leaves 1.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and a
// saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  seq_detector_param_if.slave bus
);

  localparam int LEN_W = len_w(PAT_W);
  localparam logic [LEN_W-1:0] PAT_L = LEN_W'(PAT_W);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             match_q;

  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic [LEN_W-1:0] eff_len;
  logic [PAT_W-1:0] mask;
  logic             accept;
  logic             hit;

  assign hist_shift = {hist_q[PAT_W-2:0], bus.in_bit};
  assign fill_inc   = (fill_q == PAT_L) ? fill_q : fill_q + LEN_W'(1);
  assign eff_len    = (bus.cfg_len > PAT_L) ? PAT_L : bus.cfg_len;

  // Only the low len bits take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign accept = (state_q == ARMED) && bus.in_valid && !bus.cfg_we;
  assign hit    = accept && (fill_inc >= len_q) &&
                  (((hist_shift ^ pattern_q) & mask) == '0);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    if (bus.cfg_we) begin
      pattern_d = bus.cfg_pattern;
      len_d     = eff_len;
      overlap_d = bus.cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = (eff_len == '0) ? IDLE : ARMED;
    end else if (accept) begin
      hist_d = hist_shift;
      // Non-overlapping mode needs len fresh bits after every hit.
      fill_d = (hit && !overlap_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= hit;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (bus.cnt_clr),
    .count (bus.match_count)
  );

  assign bus.armed     = (state_q == ARMED);
  assign bus.match     = match_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param with a bit-queue
// reference model and a decoupled scoreboard.
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int EW    = 2 + CNT_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard: expected {armed, match, count} after each edge.
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  string         phase       = "reset";

  // Reference model: the bits seen since the last load or consumed match.
  bit       m_bits[$];
  bit       m_armed   = 1'b0;
  int       m_len     = 0;
  int       m_pat     = 0;
  bit       m_ov      = 1'b0;
  int       m_count   = 0;

  task automatic step(input bit r, input bit we, input logic [PAT_W-1:0] pat,
                      input logic [LEN_W-1:0] len, input bit ov, input bit v,
                      input bit b, input bit clr);
    bit hit;
    int val;
    @(negedge clk);
    rst             = r;
    bus.cfg_we      = we;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ov;
    bus.in_valid    = v;
    bus.in_bit      = b;
    bus.cnt_clr     = clr;
    hit = 1'b0;
    if (r) begin
      m_bits.delete();
      m_armed = 1'b0;
      m_len   = 0;
      m_pat   = 0;
      m_ov    = 1'b0;
      m_count = 0;
    end else begin
      if (we) begin
        m_len   = (int'(len) > PAT_W) ? PAT_W : int'(len);
        m_pat   = int'(pat);
        m_ov    = ov;
        m_armed = (m_len != 0);
        m_bits.delete();
      end else if (m_armed && v) begin
        m_bits.push_back(b);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        if (m_bits.size() >= m_len) begin
          val = 0;
          for (int i = 0; i < m_len; i++)
            val = val | (int'(m_bits[m_bits.size() - 1 - i]) << i);
          hit = (val == (m_pat & ((1 << m_len) - 1)));
        end
        if (hit && !m_ov) m_bits.delete();
      end
      if (clr) m_count = hit ? 1 : 0;
      else if (hit && m_count < CMAX) m_count++;
    end
    exp_q.push_back({m_armed, hit, CNT_W'(m_count)});
    name_q.push_back(phase);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                      input bit ov);
    step(0, 1, pat, len, ov, 0, 0, 0);
  endtask

  task automatic send(input bit b);
    step(0, 0, '0, '0, 0, 1, b, 0);
  endtask

  task automatic gap();
    step(0, 0, '0, '0, 0, 0, 0, 0);
  endtask

  // Send the n low bits of seq, most significant first.
  task automatic send_seq(input logic [15:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) send(seq[i]);
  endtask

  // Monitor: samples 1 time unit after each active edge.
  always @(posedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] got_v;
    string         nm;
    #1;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {bus.armed, bus.match, bus.match_count};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s @%0t: got armed=%0b match=%0b count=%0d, expected armed=%0b match=%0b count=%0d",
                 nm, $time, got_v[EW-1], got_v[EW-2], got_v[CNT_W-1:0],
                 exp_v[EW-1], exp_v[EW-2], exp_v[CNT_W-1:0]);
      end
    end
  end

  initial begin
    bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
    bus.in_valid = 0; bus.in_bit = 0; bus.cnt_clr = 0;
    reset_cycles(3);

    phase = "overlap";
    load(8'b1011, 4, 1);
    send_seq(16'b1011011, 7);
    gap();

    phase = "non_overlap";
    step(0, 1, 8'b1011, 4, 0, 0, 0, 1);
    send_seq(16'b1011011, 7);
    gap();

    phase = "len_clamp";
    load(8'hA5, 12, 1);
    send_seq(16'hA5, 8);
    phase = "len_mask";
    load(8'hF5, 3, 1);
    send_seq(16'b101, 3);

    phase = "stall";
    load(8'b1011, 4, 1);
    send(1); gap(); send(0); gap(); gap(); send(1); gap(); send(1);
    phase = "reload";
    send_seq(16'b101, 3);
    step(0, 1, 8'b1011, 4, 1, 1, 1, 0);
    send(1);
    send_seq(16'b1011, 4);

    phase = "len_zero";
    load(8'hFF, 0, 1);
    for (int i = 0; i < 12; i++) send(1'($urandom_range(0, 1)));

    phase = "saturate";
    step(0, 1, 8'b1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 18; i++) send(1);
    phase = "clr_with_hit";
    step(0, 0, '0, '0, 0, 1, 1, 1);
    step(0, 0, '0, '0, 0, 0, 0, 1);

    phase = "reset_mid";
    load(8'b1011, 4, 1);
    send_seq(16'b101, 3);
    step(1, 0, '0, '0, 0, 1, 1, 0);
    send(1);
    gap();

    phase = "random";
    for (int t = 0; t < 25; t++) begin
      step(0, 1, PAT_W'($urandom_range(0, 255)), LEN_W'($urandom_range(0, 9)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      for (int k = 0; k < 30; k++) begin
        step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
             PAT_W'($urandom_range(0, 255)), LEN_W'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      end
    end

    gap();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending samples, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
